// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and default sizes for the UART transmit arbiter
package uart_arb_pkg;
  typedef enum logic {ST_IDLE, ST_SEND} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_PKT_DEF = 64;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick of the first request after ptr
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);
  logic [PW-1:0] idx;
  assign any = |req;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one uart_tx among N_REQ byte streams
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = BYTE_W,
  parameter int MAX_PKT = MAX_PKT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_data_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);
  localparam int PW = $clog2(N_REQ);
  state_t state;
  logic [7:0] byte_cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] own_idx;
  logic [DATA_W-1:0] own_data;
  logic own_last;
  logic [N_REQ-1:0] arb_gnt;
  logic arb_any;
  logic accept;
  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .any(arb_any)
  );
  assign busy = state == ST_SEND;
  assign req_ready = (busy && !tx_data_valid) ? grant : '0;
  assign accept = |(req_valid & req_ready);
  always_comb begin
    own_idx = '0;
    own_data = '0;
    own_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      own_idx = grant[i] ? PW'(i) : own_idx;
      own_data = grant[i] ? req_data[i*DATA_W +: DATA_W] : own_data;
      own_last = grant[i] ? req_last[i] : own_last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      byte_cnt <= '0;
      rr_ptr <= PW'(N_REQ - 1);
      tx_data <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      if (tx_data_valid && tx_data_ready) tx_data_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (arb_any) begin
          state <= ST_SEND;
          grant <= arb_gnt;
          byte_cnt <= '0;
        end
      end else if (accept) begin
        tx_data <= own_data;
        tx_data_valid <= 1'b1;
        byte_cnt <= byte_cnt + 8'd1;
        if (own_last || byte_cnt == 8'(MAX_PKT - 1)) begin
          rr_ptr <= own_idx;
          grant <= '0;
          state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed table and sequence checks for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] req_data;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic [7:0] tx_data;
  logic tx_data_valid;
  logic tx_data_ready;
  logic [3:0] grant;
  logic busy;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[10];
  uart_tx_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .grant(grant),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    tx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic send_byte(input int r, input logic [7:0] d, input logic l, input logic rel);
    int t;
    logic [3:0] eg;
    t = 0;
    eg = rel ? 4'd0 : 4'b0001 << r;
    req_valid[r] = 1'b1;
    req_data[r*8 +: 8] = d;
    req_last[r] = l;
    while (!req_ready[r] && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    chk("ready_timeout", 32'(t < 200), 32'd1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
    chk("byte_data", 32'(tx_data), 32'(d));
    chk("byte_valid", 32'(tx_data_valid), 32'd1);
    chk("byte_grant", 32'(grant), 32'(eg));
    chk("byte_busy", 32'(busy), 32'(!rel));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{4'b1111, 4'b0001, 8'h10};
    vecs[1] = '{4'b1111, 4'b0010, 8'h11};
    vecs[2] = '{4'b1001, 4'b1000, 8'h13};
    vecs[3] = '{4'b1001, 4'b0001, 8'h10};
    vecs[4] = '{4'b0100, 4'b0100, 8'h12};
    vecs[5] = '{4'b0101, 4'b0001, 8'h10};
    vecs[6] = '{4'b1110, 4'b0010, 8'h11};
    vecs[7] = '{4'b0010, 4'b0010, 8'h11};
    vecs[8] = '{4'b1101, 4'b0100, 8'h12};
    vecs[9] = '{4'b1011, 4'b1000, 8'h13};
    do_reset();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      req_data = 32'h13121110;
      req_last = 4'hF;
      req_valid = vecs[i].valid;
      @(posedge clk);
      #1 chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1 req_valid = '0;
      chk($sformatf("vec%0d_data", i), 32'({tx_data_valid, tx_data}), 32'({1'b1, vecs[i].exp_data}));
      chk($sformatf("vec%0d_release", i), 32'({busy, grant}), 32'd0);
      @(posedge clk);
      #1 chk($sformatf("vec%0d_drain", i), 32'(tx_data_valid), 32'd0);
    end
    do_reset();
    send_byte(1, 8'h41, 1'b0, 1'b0);
    send_byte(1, 8'h42, 1'b0, 1'b0);
    send_byte(1, 8'h43, 1'b1, 1'b1);
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      req_valid[2] = 1'b1;
      req_data[23:16] = 8'h20;
      send_byte(0, 8'h01, 1'b0, 1'b0);
      send_byte(0, 8'h02, 1'b1, 1'b1);
      send_byte(2, 8'h20, 1'b0, 1'b0);
      send_byte(2, 8'h21, 1'b1, 1'b1);
      req_valid[0] = 1'b1;
    end
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 70; i++) send_byte(3, 8'(i), 1'b0, 1'(i == 63));
    do_reset();
    tx_data_ready = 1'b0;
    send_byte(1, 8'h55, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h56;
    req_last[1] = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1 chk("hold_low", 32'({tx_data_valid, tx_data, req_ready}), 32'({1'b1, 8'h55, 4'b0000}));
    end
    tx_data_ready = 1'b1;
    send_byte(1, 8'h56, 1'b1, 1'b1);
    do_reset();
    send_byte(1, 8'hA0, 1'b0, 1'b0);
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h0F;
    req_last[0] = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1 chk("owner_gap", 32'({grant, req_ready[0], tx_data}), 32'({4'b0010, 1'b0, 8'hA0}));
    end
    send_byte(1, 8'hA1, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk("gap_next_owner", 32'(grant), 32'b0001);
    send_byte(0, 8'h0F, 1'b1, 1'b1);
    do_reset();
    send_byte(2, 8'h31, 1'b0, 1'b0);
    send_byte(2, 8'h32, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'({tx_data, tx_data_valid, grant, busy, req_ready}), 32'd0);
    #1 rst_n = 1'b1;
    req_valid = 4'b0101;
    req_last = 4'b0101;
    @(posedge clk);
    #1 chk("post_rst_grant", 32'(grant), 32'b0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-atomic arbiter that shares one `uart_tx` instance between `N_REQ` byte-stream requesters. Each requester presents bytes with a `last` marker. Once granted, a requester owns the transmitter until its `last` byte, or until `MAX_PKT` bytes, has been accepted. The block sits between the requester logic and `uart_tx`, and drives `uart_tx`'s `tx_data`/`tx_data_valid`/`tx_data_ready` handshake directly.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width. Fixed at 8 to match `uart_tx`.
- `MAX_PKT`, 64: maximum bytes per grant before forced release (1..255).
- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `req_data` in `N_REQ*8`: requester i byte at bits [8i+7:8i].
- `req_valid` in `N_REQ`: requester i has a byte.
- `req_last` in `N_REQ`: byte on requester i ends its packet.
- `req_ready` out `N_REQ`: byte from requester i accepted this cycle when `valid & ready`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_data_valid` out 1: `tx_data` holds a byte for `uart_tx`.
- `tx_data_ready` in 1: `uart_tx` accepts when `tx_data_valid & tx_data_ready`.
- `grant` out `N_REQ`: one-hot owner, all-zero in IDLE.
- `busy` out 1: state is SEND.

## Operation
- States:
  - IDLE: no owner.
  - SEND: owner `grant` streams bytes.
- IDLE → SEND:
  - Any `req_valid` high selects the first valid index strictly after `rr_ptr`, wrapping modulo `N_REQ`.
  - The winner is registered into `grant`, and `byte_cnt` is cleared to 0.
  - With no `req_valid`, the block stays in IDLE.
- `req_ready[i]` is combinational: `(state==SEND) & grant[i] & ~tx_data_valid`. All other `req_ready` bits are 0.
- Byte accept (`req_valid[g] & req_ready[g]`):
  - `tx_data <= req_data[g]`, `tx_data_valid <= 1`, `byte_cnt++`.
  - If `req_last[g]` is set, or `byte_cnt+1 == MAX_PKT`: `rr_ptr <= g`, clear `grant`, next state IDLE.
- Output handshake: `tx_data_valid & tx_data_ready` sets `tx_data_valid <= 0` next cycle. `tx_data` holds its value.
- `tx_data`/`tx_data_valid` are stable while `tx_data_valid=1` and `tx_data_ready=0`.
- An owner dropping `req_valid` mid-packet keeps the grant. There is no preemption other than `MAX_PKT`.
- A new arbitration may complete while the last byte of the previous packet is still in `tx_data`. The new owner's first accept waits for `tx_data_valid=0`.
- `byte_cnt` is 8 bits, saturates by construction at `MAX_PKT`, and never wraps.
- `rr_ptr` resets to `N_REQ-1`, so requester 0 has first priority after reset.

## Timing
- Reset values: `tx_data=0`, `tx_data_valid=0`, `grant=0`, `busy=0`, `req_ready=0`, state IDLE, `rr_ptr=N_REQ-1`, `byte_cnt=0`.
- `req_valid` rising in IDLE at cycle 0:
  - `grant`/`busy` high at cycle 1.
  - `req_ready` high at cycle 1 if `tx_data_valid=0`.
  - `tx_data_valid` high at cycle 2.
- Byte rate: at most one byte per two cycles. This is a bubble after each output handshake; it is irrelevant against UART byte time.
- Last-byte accept at cycle k: `grant=0`, `busy=0` at k+1. Earliest next grant at k+2.
- Simultaneous output handshake and new owner byte in the same cycle cannot occur, because `req_ready` is gated by `~tx_data_valid`.
- Reset mid-packet:
  - Everything clears immediately, and the partial packet is abandoned.
  - A byte already latched inside `uart_tx` completes on the line independently.

## Structure
- Package `uart_arb_pkg` holds:
  - state encoding (`ST_IDLE`, `ST_SEND`)
  - default `N_REQ`/`MAX_PKT` constants
  - `BYTE_W=8`
- Sub-module `rr_arbiter` is purely combinational:
  - inputs: `req[N_REQ]`, `ptr`
  - outputs: one-hot `gnt`, `any`
  - rotate-priority search starting at `ptr+1`
- The top holds the FSM, `byte_cnt`, `rr_ptr` and the output register.

## Test plan
- Single packet from req 1 (0x41, 0x42, 0x43 with `last` on 0x43), `tx_data_ready` pulsed per byte:
  - `grant=0010`.
  - `tx_data` shows 41, 42, 43 in order.
  - IDLE 1 cycle after the 0x43 accept.
- Req 0 and req 2 both valid from reset, 2-byte packets each:
  - req 0 served first, then req 2.
  - Repeat with both valid again: order is 0 then 2 (pointer wraps after 2 to 0).
- Req 3 streams 70 bytes, never sets `last`, `MAX_PKT=64`:
  - grant released after byte 64.
  - req 3 re-granted (only requester) for the remaining 6 bytes.
- `tx_data_ready` held low 100 cycles with a byte loaded:
  - `tx_data_valid` stays 1, `tx_data` stable, all `req_ready=0`.
- Owner req 1 drops `req_valid` for 50 cycles mid-packet while req 0 is valid:
  - `grant` stays `0010`.
  - req 0 not served until req 1's `last` byte.
- `rst_n` asserted during byte 2 of a 4-byte packet:
  - all outputs return to reset values asynchronously.
  - after release, req 0 is granted first.
